// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: issues sequential word fetches into a small circular
// buffer, throttled by free space, and flushes and redirects on a branch.
module fetch_prefetch_unit #(
  parameter int unsigned BUFFER_DEPTH  = 4,
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        fetch_o,
  output logic        invalidate_o,
  output logic [31:0] fetch_address_o,
  input  logic [31:0] fetch_instruction_i,
  input  logic        fetch_valid_i,
  input  logic        branch_i,
  input  logic [31:0] branch_address_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);
  localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      pc_q, pc_d;
  logic             inflight_q;
  logic [31:0]      inflight_addr_q;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_buf_q [BUFFER_DEPTH];
  logic [31:0]      pc_buf_q    [BUFFER_DEPTH];

  logic             fetch;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   pending;

  // Outstanding request counts as occupied so a response always has a slot.
  assign pending = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign fetch   = rst_n_i && !branch_i && (pending < (CNT_W+1)'(BUFFER_DEPTH));
  assign push    = fetch_valid_i && inflight_q && !branch_i;
  assign pop     = instr_valid_o && instr_ready_i;

  assign fetch_o         = fetch;
  assign invalidate_o    = rst_n_i && branch_i;
  assign fetch_address_o = pc_q;
  assign instr_valid_o   = (count_q != '0) && !branch_i;
  assign instr_o         = instr_buf_q[rd_ptr_q];
  assign instr_pc_o      = pc_buf_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (branch_i) begin
      pc_d     = {branch_address_i[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch) pc_d = pc_q + 32'd4;
      if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q            <= RESET_ADDRESS;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= fetch;
      if (fetch) inflight_addr_q <= pc_q;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_buf_q[wr_ptr_q] <= fetch_instruction_i;
      pc_buf_q[wr_ptr_q]    <= inflight_addr_q;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised bench for fetch_prefetch_unit: a one-cycle memory, an expected
// instruction-stream scoreboard and a cycle monitor checking fetch and decode sides.
module tb_fetch_prefetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        fetch_o, invalidate_o, instr_valid_o;
  logic [31:0] fetch_address_o, instr_o, instr_pc_o;
  logic [31:0] fetch_instruction_i;
  logic        fetch_valid_i;
  logic        branch_i = 1'b0;
  logic [31:0] branch_address_i = '0;
  logic        instr_ready_i = 1'b0;
  logic        spur = 1'b0;

  logic        mem_pend_q = 1'b0;
  logic [31:0] mem_addr_q = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] tail_addr;

  int          m_occ, m_infl, stall;
  logic [31:0] m_pc;
  logic        e_fetch, e_valid, e_pop, m_push;
  logic [31:0] got_pc;

  fetch_prefetch_unit #(.BUFFER_DEPTH(DEPTH), .RESET_ADDRESS(RST_ADDR)) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .fetch_o             (fetch_o),
    .invalidate_o        (invalidate_o),
    .fetch_address_o     (fetch_address_o),
    .fetch_instruction_i (fetch_instruction_i),
    .fetch_valid_i       (fetch_valid_i),
    .branch_i            (branch_i),
    .branch_address_i    (branch_address_i),
    .instr_valid_o       (instr_valid_o),
    .instr_ready_i       (instr_ready_i),
    .instr_o             (instr_o),
    .instr_pc_o          (instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  // Memory answers every request one cycle later; it has no reset, so a
  // request issued just before a reset still answers afterwards.
  always @(posedge clk_i) begin
    mem_pend_q <= fetch_o && !invalidate_o;
    mem_addr_q <= fetch_address_o;
  end
  assign fetch_valid_i       = mem_pend_q | spur;
  assign fetch_instruction_i = mem_pend_q ? mem_word(mem_addr_q) : 32'hBAD0_0BAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the expected decode stream is the sequential run of words
  // starting at the most recent redirect or reset address.
  task automatic refill();
    while (exp_q.size() < 40) begin
      exp_q.push_back(tail_addr);
      tail_addr = tail_addr + 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    tail_addr = {a[31:2], 2'b00};
    refill();
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    refill();
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_i         = 1'b1;
    branch_address_i = a;
    restart(a);
  endtask

  task automatic do_reset(input int hold);
    rst_n_i  = 1'b0;
    branch_i = 1'b0;
    spur     = 1'b0;
    restart(RST_ADDR);
    if (hold == 0) #2;
    else repeat (hold) step();
    rst_n_i = 1'b1;
  endtask

  always @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      #1;
      check("rst_fetch_o",       {31'b0, fetch_o},       32'd0);
      check("rst_invalidate_o",  {31'b0, invalidate_o},  32'd0);
      check("rst_instr_valid_o", {31'b0, instr_valid_o}, 32'd0);
      m_occ  = 0;
      m_infl = 0;
      m_pc   = RST_ADDR;
      stall  = 0;
    end else begin
      e_fetch = !branch_i && ((m_occ + m_infl) < int'(DEPTH));
      check("fetch_o", {31'b0, fetch_o}, {31'b0, e_fetch});
      if (e_fetch && fetch_o) check("fetch_address_o", fetch_address_o, m_pc);
      check("invalidate_o", {31'b0, invalidate_o}, {31'b0, branch_i});
      e_valid = (m_occ != 0) && !branch_i;
      check("instr_valid_o", {31'b0, instr_valid_o}, {31'b0, e_valid});
      e_pop = e_valid && instr_ready_i;
      if (e_pop) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          got_pc = exp_q.pop_front();
          check("instr_pc_o", instr_pc_o, got_pc);
          check("instr_o", instr_o, mem_word(got_pc));
        end
      end
      m_push = (m_infl != 0) && !branch_i;
      if (branch_i) begin
        m_occ  = 0;
        m_infl = 0;
        m_pc   = {branch_address_i[31:2], 2'b00};
      end else begin
        m_occ  = m_occ + (m_push ? 1 : 0) - (e_pop ? 1 : 0);
        if (e_fetch) m_pc = m_pc + 32'd4;
        m_infl = e_fetch ? 1 : 0;
      end
      if (e_pop || branch_i || !instr_ready_i) stall = 0;
      else stall++;
      if (stall > 16) begin
        check("progress_timeout", 32'(stall), 32'd0);
        stall = 0;
      end
    end
  end

  initial begin
    instr_ready_i = 1'b1;
    restart(RST_ADDR);
    #1;
    do_reset(3);
    repeat (20) step();

    instr_ready_i = 1'b0;
    repeat (10) step();
    instr_ready_i = 1'b1;
    repeat (8) step();

    do_reset(1);
    step();
    step();
    step();
    do_branch(32'h0000_0103);
    step();
    branch_i = 1'b0;
    repeat (10) step();

    do_branch(32'hFFFF_FFFC);
    step();
    branch_i = 1'b0;
    repeat (10) step();

    do_branch(32'h0000_0200);
    step();
    do_branch(32'h0000_0300);
    step();
    branch_i = 1'b0;
    repeat (8) step();

    instr_ready_i = 1'b0;
    do_branch(32'h0000_0040);
    step();
    branch_i = 1'b0;
    repeat (3) step();
    do_reset(0);
    instr_ready_i = 1'b1;
    repeat (12) step();

    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(0, 2));
        continue;
      end
      instr_ready_i = ($urandom_range(0, 9) < 7);
      spur          = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) < 6) do_branch($urandom());
      else branch_i = 1'b0;
    end
    branch_i      = 1'b0;
    spur          = 1'b0;
    instr_ready_i = 1'b1;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
